dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Round-robin arbiter that shares the two ports of the dual-port data memory among `NUM_REQ` matrix-multiply cores. Each cycle it grants up to two requesters, one per memory port. It also blocks same-address write hazards between the ports and returns read data to the requester through a registered, one-cycle-latency response path. It sits between the core array and the data memory, and it is the only master of the memory ports.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting cores (2..16).
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `MEM_DEPTH`, 1000: number of valid words. Addresses `>= MEM_DEPTH` are out of range.

Ports (per-requester vectors are flattened, requester 0 in the LSBs):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  access request, one bit per requester.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  request addresses.
- `req_wdata`  in  NUM_REQ*DATA_W  write data.
- `gnt`  out  NUM_REQ  access performed this cycle (combinational).
- `rvalid`  out  NUM_REQ  registered read-data valid, one cycle after a read grant.
- `rdata`  out  NUM_REQ*DATA_W  registered read data per requester.
- `addr_err`  out  NUM_REQ  registered pulse, one cycle after a grant to an out-of-range address.
- `mem_addr_a`, `mem_addr_b`  out  ADDR_W  memory port addresses.
- `mem_din_a`, `mem_din_b`  out  DATA_W  memory write data.
- `mem_we_a`, `mem_we_b`  out  1  memory write enables.
- `mem_dout_a`, `mem_dout_b`  in  DATA_W  memory read data (combinational from address).
- `perf_grants`, `perf_conflicts`, `perf_waits`  out  32  performance counters (see Configuration).

## Operation
- `rr_ptr` (log2 NUM_REQ bits) is the only arbitration state.
- Candidate order: scan from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - First requester with `req`=1 gets port A.
  - Next requester with `req`=1 gets port B.
- Conflict rule: if the A and B candidates have equal `req_addr` and either one writes, B is not granted and port B stays idle (`mem_we_b`=0). Two reads to the same address are both granted.
- Pointer update: `rr_ptr` <= (index of last granted requester + 1) mod NUM_REQ. If nothing is granted, `rr_ptr` holds.
  - A conflict-denied B candidate becomes the first candidate in the next cycle, which guarantees no starvation.
- Granted write: memory write enable asserted for that port, data committed at the end-of-cycle edge. `rvalid` stays 0.
- Granted read: on the next edge, `rdata[i]` captures the port's `mem_dout` and `rvalid[i]` goes to 1 for one cycle.
- Out-of-range address: grant is still issued, the write is suppressed (`mem_we` forced 0), read data is returned as 0, and `addr_err[i]` pulses.
- Idle ports: `mem_addr`=0, `mem_din`=0, `mem_we`=0.
- While `rst`=1: `gnt`=0 and both `mem_we`=0, forced combinationally, so no memory write occurs during reset.

## Timing
- Request to `gnt` to memory access: 0 cycles (same cycle). Write data lands at the rising edge that ends the grant cycle.
- Read latency: `rvalid`/`rdata` are valid exactly 1 cycle after `gnt`.
- A requester holds `req`, `req_we`, `req_addr` and `req_wdata` stable until it sees `gnt`. It may drop or change `req` in the cycle after `gnt`.
- Back-to-back grants to the same requester are allowed when it is the only requester.
- Reset values: `rr_ptr`=0, `rvalid`=0, `rdata`=0, `addr_err`=0, all counters 0.
- Reset mid-operation: pending `rvalid` pulses are dropped. After release, arbitration restarts from requester 0.
- Throughput: at most 2 accesses per cycle.

## Configuration
Macro `DMEM_ARB_PERF_EN`.
- Defined:
  - `perf_grants` counts granted accesses (+0, +1 or +2 per cycle).
  - `perf_conflicts` counts cycles with a conflict-denied B candidate.
  - `perf_waits` counts requester-cycles with `req`=1 and `gnt`=0.
  - All counters saturate at 2^32-1 and clear only on `rst`.
- Undefined: no counter logic is present and all three outputs are tied to 0.

## Structure
- `dmem_arb_pkg` holds `PERF_CNT_W`=32 and the port-select encoding (`PORT_NONE`, `PORT_A`, `PORT_B`, 2 bits).
- Sub-module `dmem_rr_pick`: combinational "first set bit at or after pointer, with wrap" over a `NUM_REQ` mask. Instantiate it twice:
  - once on `req` for port A;
  - once on `req` with the A winner masked, for port B.

## Test plan
- Single read: `req[1]`=1, addr 5, memory holds 0x1234 → `gnt[1]`=1 that cycle; next cycle `rvalid[1]`=1, `rdata[1]`=0x1234.
- Fairness: all 4 requesters hold reads → grant pairs {0,1}, {2,3}, {0,1}, …; no requester waits more than 2 cycles.
- Write conflict: `rr_ptr`=0; req0 writes addr 7, req1 reads addr 7 → only `gnt[0]`. Next cycle req1 is granted and reads the new value. With `DMEM_ARB_PERF_EN`, `perf_conflicts`=1.
- Same-address reads: req2 and req3 both read addr 9 → both granted, both get identical `rdata` one cycle later.
- Out of range: req0 writes addr 1000 → `gnt[0]`=1, `mem_we_a`=0, `addr_err[0]` pulses next cycle, memory unchanged.
- Reset mid-read: assert `rst` in the cycle after a read grant → `rvalid`=0 immediately, no write occurs, and after release requester 0 has priority.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int unsigned PERF_CNT_W = 32;

  // Which memory port, if any, serves a requester this cycle.
  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_A    = 2'd1,
    PORT_B    = 2'd2
  } port_sel_e;

  function automatic logic [PERF_CNT_W-1:0] sat_add(
    input logic [PERF_CNT_W-1:0] a,
    input logic [PERF_CNT_W-1:0] b
  );
    logic [PERF_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PERF_CNT_W] ? '1 : s[PERF_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// First set bit of a mask at or after a pointer, wrapping modulo NUM_REQ.
module dmem_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_found_c,
  output logic [PTR_W-1:0]   o_idx_c
);

  always_comb begin
    o_found_c = 1'b0;
    o_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!o_found_c && i_mask[PTR_W'((32'(i_ptr) + k) % NUM_REQ)]) begin
        o_found_c = 1'b1;
        o_idx_c   = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the two data-memory ports among NUM_REQ cores.
// Optional performance counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [NUM_REQ*DATA_W-1:0]   rdata,
  output logic [NUM_REQ-1:0]          addr_err,
  output logic [ADDR_W-1:0]           mem_addr_a,
  output logic [ADDR_W-1:0]           mem_addr_b,
  output logic [DATA_W-1:0]           mem_din_a,
  output logic [DATA_W-1:0]           mem_din_b,
  output logic                        mem_we_a,
  output logic                        mem_we_b,
  input  logic [DATA_W-1:0]           mem_dout_a,
  input  logic [DATA_W-1:0]           mem_dout_b,
  output logic [PERF_CNT_W-1:0]       perf_grants,
  output logic [PERF_CNT_W-1:0]       perf_conflicts,
  output logic [PERF_CNT_W-1:0]       perf_waits
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [NUM_REQ-1:0] r_addr_err;
  logic [DATA_W-1:0]  r_rdata [NUM_REQ];

  logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata [NUM_REQ];
  logic [NUM_REQ-1:0] w_oor;
  port_sel_e          w_sel   [NUM_REQ];

  logic               w_a_found, w_b_found;
  logic [PTR_W-1:0]   w_a_idx, w_b_idx, w_last, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_mask_b;
  logic               w_conflict, w_a_gnt, w_b_gnt;

  // Unflatten per-requester fields and flag out-of-range addresses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
      w_oor[i]   = (32'(w_addr[i]) >= MEM_DEPTH);
    end
  end

  dmem_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick_a (
    .i_mask    (req),
    .i_ptr     (r_rr_ptr),
    .o_found_c (w_a_found),
    .o_idx_c   (w_a_idx)
  );

  // Masking the A winner and scanning from the same pointer yields the next requester after A.
  assign w_mask_b = req & ~(NUM_REQ'(w_a_found) << w_a_idx);

  dmem_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick_b (
    .i_mask    (w_mask_b),
    .i_ptr     (r_rr_ptr),
    .o_found_c (w_b_found),
    .o_idx_c   (w_b_idx)
  );

  assign w_conflict = w_a_found && w_b_found &&
                      (w_addr[w_a_idx] == w_addr[w_b_idx]) &&
                      (req_we[w_a_idx] || req_we[w_b_idx]);
  assign w_a_gnt    = w_a_found && !rst;
  assign w_b_gnt    = w_b_found && !w_conflict && !rst;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sel[i] = PORT_NONE;
    end
    if (w_a_gnt) w_sel[w_a_idx] = PORT_A;
    if (w_b_gnt) w_sel[w_b_idx] = PORT_B;
  end

  always_comb begin
    gnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt[i] = (w_sel[i] != PORT_NONE);
    end
  end

  // Memory port drive; out-of-range writes keep their grant but never reach the array.
  always_comb begin
    mem_addr_a = '0;
    mem_din_a  = '0;
    mem_we_a   = 1'b0;
    mem_addr_b = '0;
    mem_din_b  = '0;
    mem_we_b   = 1'b0;
    if (w_a_gnt) begin
      mem_addr_a = w_addr[w_a_idx];
      mem_din_a  = req_we[w_a_idx] ? w_wdata[w_a_idx] : '0;
      mem_we_a   = req_we[w_a_idx] && !w_oor[w_a_idx];
    end
    if (w_b_gnt) begin
      mem_addr_b = w_addr[w_b_idx];
      mem_din_b  = req_we[w_b_idx] ? w_wdata[w_b_idx] : '0;
      mem_we_b   = req_we[w_b_idx] && !w_oor[w_b_idx];
    end
  end

  assign w_last    = w_b_gnt ? w_b_idx : w_a_idx;
  assign w_ptr_nxt = (32'(w_last) == NUM_REQ - 1) ? '0 : w_last + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_a_gnt) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  // One-cycle read response path, routed back from whichever port served the requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid   <= '0;
      r_addr_err <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_rdata[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_rvalid[i]   <= gnt[i] && !req_we[i];
        r_addr_err[i] <= gnt[i] && w_oor[i];
        if (gnt[i] && !req_we[i]) begin
          if (w_oor[i])                r_rdata[i] <= '0;
          else if (w_sel[i] == PORT_A) r_rdata[i] <= mem_dout_a;
          else                         r_rdata[i] <= mem_dout_b;
        end
      end
    end
  end

  assign rvalid   = r_rvalid;
  assign addr_err = r_addr_err;

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rdata[i*DATA_W +: DATA_W] = r_rdata[i];
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] w_n_gnt, w_n_wait;
  logic [PERF_CNT_W-1:0] r_perf_grants, r_perf_conflicts, r_perf_waits;

  always_comb begin
    w_n_gnt  = '0;
    w_n_wait = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_n_gnt  = w_n_gnt + PERF_CNT_W'(gnt[i]);
      w_n_wait = w_n_wait + PERF_CNT_W'(req[i] && !gnt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_grants    <= '0;
      r_perf_conflicts <= '0;
      r_perf_waits     <= '0;
    end else begin
      r_perf_grants    <= sat_add(r_perf_grants, w_n_gnt);
      r_perf_conflicts <= sat_add(r_perf_conflicts, PERF_CNT_W'(w_conflict));
      r_perf_waits     <= sat_add(r_perf_waits, w_n_wait);
    end
  end

  assign perf_grants    = r_perf_grants;
  assign perf_conflicts = r_perf_conflicts;
  assign perf_waits     = r_perf_waits;
`else
  assign perf_grants    = '0;
  assign perf_conflicts = '0;
  assign perf_waits     = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed scoreboard bench for dmem_port_arbiter with a behavioural dual-port memory.
module tb_dmem_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, rvalid, addr_err;
  logic [N*DW-1:0] rdata;
  logic [AW-1:0]   mem_addr_a, mem_addr_b;
  logic [DW-1:0]   mem_din_a, mem_din_b, mem_dout_a, mem_dout_b;
  logic            mem_we_a, mem_we_b;
  logic [31:0]     perf_grants, perf_conflicts, perf_waits;

  logic [15:0]     mem [1024];
  logic            mem_init;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .addr_err(addr_err), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_din_a(mem_din_a), .mem_din_b(mem_din_b), .mem_we_a(mem_we_a),
    .mem_we_b(mem_we_b), .mem_dout_a(mem_dout_a), .mem_dout_b(mem_dout_b),
    .perf_grants(perf_grants), .perf_conflicts(perf_conflicts), .perf_waits(perf_waits)
  );

  function automatic logic [15:0] init_val(input int a);
    if (a == 5)             return 16'h1234;
    if (a == 7)             return 16'h0777;
    if (a == 9)             return 16'hBEEF;
    if (a >= 10 && a <= 13) return 16'hA000 + 16'(a - 10);
    return 16'(a) ^ 16'h1100;
  endfunction

  // Memory model: combinational read, write at the rising edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 1024; a++) mem[a] <= init_val(a);
    end else begin
      if (mem_we_a) mem[mem_addr_a[9:0]] <= mem_din_a;
      if (mem_we_b) mem[mem_addr_b[9:0]] <= mem_din_b;
    end
  end
  assign mem_dout_a = mem[mem_addr_a[9:0]];
  assign mem_dout_b = mem[mem_addr_b[9:0]];

  typedef struct {
    string       tag;
    int          idx;
    logic        rd;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    req[i]                 = 1'b1;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = addr;
    req_wdata[i*DW +: DW]  = wd;
  endtask

  task automatic clr_req();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic push(input string tag, input int idx, input logic rd, input logic err, input logic [15:0] data);
    exp_t e;
    e.tag = tag; e.idx = idx; e.rd = rd; e.err = err; e.data = data;
    sb.push_back(e);
  endtask

  // Compare the registered response of the previous cycle against the scoreboard.
  task automatic check_resp();
    logic [N-1:0] erv, eer;
    exp_t e;
    erv = '0; eer = '0;
    foreach (sb[k]) begin
      if (sb[k].rd)  erv[sb[k].idx] = 1'b1;
      if (sb[k].err) eer[sb[k].idx] = 1'b1;
    end
    chk("rvalid", 64'(rvalid), 64'(erv));
    chk("addr_err", 64'(addr_err), 64'(eer));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.rd) chk({e.tag, "_rdata"}, 64'(rdata[e.idx*DW +: DW]), 64'(e.data));
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    check_resp();
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    clr_req();
    // Pending writes during reset must not reach memory.
    set_req(0, 1'b1, 16'd3, 16'hDEAD);
    set_req(1, 1'b1, 16'd4, 16'hCAFE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_we_a", 64'(mem_we_a), 64'h0);
    chk("rst_we_b", 64'(mem_we_b), 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_addr_err", 64'(addr_err), 64'h0);
    chk("rst_perf_grants", 64'(perf_grants), 64'h0);
    clr_req();
    rst = 1'b0;
    #1 chk("idle_gnt", 64'(gnt), 64'h0);

    // Fairness: all four hold reads, pairs alternate {0,1},{2,3},{0,1}.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'(10 + i), 16'h0);
    #1;
    chk("fair1_gnt", 64'(gnt), 64'h3);
    chk("fair1_addr_a", 64'(mem_addr_a), 64'd10);
    chk("fair1_addr_b", 64'(mem_addr_b), 64'd11);
    push("fair1_r0", 0, 1'b1, 1'b0, 16'hA000);
    push("fair1_r1", 1, 1'b1, 1'b0, 16'hA001);
    tick();
    #1 chk("fair2_gnt", 64'(gnt), 64'hC);
    push("fair2_r2", 2, 1'b1, 1'b0, 16'hA002);
    push("fair2_r3", 3, 1'b1, 1'b0, 16'hA003);
    tick();
    #1 chk("fair3_gnt", 64'(gnt), 64'h3);
    push("fair3_r0", 0, 1'b1, 1'b0, 16'hA000);
    push("fair3_r1", 1, 1'b1, 1'b0, 16'hA001);
    tick();
    clr_req();

    // Single read.
    set_req(1, 1'b0, 16'd5, 16'h0);
    #1;
    chk("single_gnt", 64'(gnt), 64'h2);
    chk("single_addr_a", 64'(mem_addr_a), 64'd5);
    push("single", 1, 1'b1, 1'b0, 16'h1234);
    tick();
    clr_req();
    #1 chk("idle_addr_a", 64'(mem_addr_a), 64'h0);
    tick();

    // Lone requester 3 brings the pointer back to 0.
    set_req(3, 1'b0, 16'd9, 16'h0);
    #1 chk("r3_gnt", 64'(gnt), 64'h8);
    push("r3", 3, 1'b1, 1'b0, 16'hBEEF);
    tick();
    clr_req();

    // Write/read conflict on addr 7: only the writer proceeds.
    set_req(0, 1'b1, 16'd7, 16'h5A5A);
    set_req(1, 1'b0, 16'd7, 16'h0);
    #1;
    chk("conf_gnt", 64'(gnt), 64'h1);
    chk("conf_we_a", 64'(mem_we_a), 64'h1);
    chk("conf_addr_a", 64'(mem_addr_a), 64'd7);
    chk("conf_din_a", 64'(mem_din_a), 64'h5A5A);
    chk("conf_we_b", 64'(mem_we_b), 64'h0);
    chk("conf_addr_b", 64'(mem_addr_b), 64'h0);
    tick();
`ifdef DMEM_ARB_PERF_EN
    chk("perf_conflicts", 64'(perf_conflicts), 64'd1);
`else
    chk("perf_conflicts", 64'(perf_conflicts), 64'd0);
`endif
    clr_req();
    set_req(1, 1'b0, 16'd7, 16'h0);
    #1 chk("conf_next_gnt", 64'(gnt), 64'h2);
    push("conf_next", 1, 1'b1, 1'b0, 16'h5A5A);
    tick();
    clr_req();

    // Same-address reads are both served.
    set_req(2, 1'b0, 16'd9, 16'h0);
    set_req(3, 1'b0, 16'd9, 16'h0);
    #1;
    chk("same_gnt", 64'(gnt), 64'hC);
    chk("same_addr_b", 64'(mem_addr_b), 64'd9);
    push("same_r2", 2, 1'b1, 1'b0, 16'hBEEF);
    push("same_r3", 3, 1'b1, 1'b0, 16'hBEEF);
    tick();
    clr_req();

    // Out-of-range write and read.
    set_req(0, 1'b1, 16'd1000, 16'hFFFF);
    #1;
    chk("oor_w_gnt", 64'(gnt), 64'h1);
    chk("oor_w_we_a", 64'(mem_we_a), 64'h0);
    push("oor_w", 0, 1'b0, 1'b1, 16'h0);
    tick();
    chk("oor_w_mem", 64'(mem[1000]), 64'(init_val(1000)));
    clr_req();
    set_req(1, 1'b0, 16'd2000, 16'h0);
    #1 chk("oor_r_gnt", 64'(gnt), 64'h2);
    push("oor_r", 1, 1'b1, 1'b1, 16'h0);
    tick();
    clr_req();

    // Reset in the cycle after a read grant.
    set_req(2, 1'b0, 16'd5, 16'h0);
    #1 chk("rstmid_gnt", 64'(gnt), 64'h4);
    push("rstmid", 2, 1'b1, 1'b0, 16'h1234);
    tick();
    clr_req();
    rst = 1'b1;
    set_req(0, 1'b1, 16'd5, 16'h0BAD);
    set_req(3, 1'b1, 16'd6, 16'h0BAD);
    #1;
    chk("rstmid_rvalid", 64'(rvalid), 64'h0);
    chk("rstmid_gnt0", 64'(gnt), 64'h0);
    chk("rstmid_we_a", 64'(mem_we_a), 64'h0);
    chk("rstmid_we_b", 64'(mem_we_b), 64'h0);
    @(posedge clk); #1;
    chk("rstmid_mem5", 64'(mem[5]), 64'h1234);
    clr_req();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'(10 + i), 16'h0);
    #1 chk("post_rst_gnt", 64'(gnt), 64'h3);
    push("post_r0", 0, 1'b1, 1'b0, 16'hA000);
    push("post_r1", 1, 1'b1, 1'b0, 16'hA001);
    tick();
    clr_req();
`ifdef DMEM_ARB_PERF_EN
    chk("perf_grants", 64'(perf_grants), 64'd2);
    chk("perf_waits", 64'(perf_waits), 64'd2);
`else
    chk("perf_grants", 64'(perf_grants), 64'd0);
    chk("perf_waits", 64'(perf_waits), 64'd0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
